// File: rtl/match_ctrl.sv
// Pong match controller: scores, rounds, serve/point pacing, ball enable and sound gating.
// All outputs are registered; events take effect on the edge after their pulse.
module match_ctrl #(
    parameter int unsigned WIN_SCORE        = 9,
    parameter int unsigned POINTS_PER_ROUND = 3,
    parameter int unsigned SERVE_FRAMES     = 60,
    parameter int unsigned POINT_FRAMES     = 30,
    parameter int unsigned SOUND_FRAMES     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic [1:0] round,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       sound_on,
    output logic       game_over
);

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [4:0] PPR       = 5'(POINTS_PER_ROUND);
    localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
    localparam logic [7:0] SOUND_CNT = 8'(SOUND_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] snd_q, snd_d;
    logic [3:0] left_q, left_d;
    logic [3:0] right_q, right_d;
    logic [1:0] round_q, round_d;
    logic [4:0] total_q, total_d;
    logic       dir_q, dir_d;
    logic       ball_q, ball_d;
    logic       sound_q, sound_d;
    logic       over_q, over_d;
    logic       start_q;
    logic       point;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snd_d   = snd_q;
        left_d  = left_q;
        right_d = right_q;
        round_d = round_q;
        total_d = total_q;
        dir_d   = dir_q;
        point   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SERVE;
                    cnt_d   = SERVE_CNT;
                    left_d  = '0;
                    right_d = '0;
                    round_d = '0;
                    total_d = '0;
                    dir_d   = 1'b0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // Simultaneous misses cancel out: no point, play continues.
                if (miss_left ^ miss_right) begin
                    point = 1'b1;
                    if (miss_left) begin
                        if (right_q < WIN) right_d = right_q + 4'd1;
                        dir_d = 1'b0;
                    end else begin
                        if (left_q < WIN) left_d = left_q + 4'd1;
                        dir_d = 1'b1;
                    end
                    total_d = total_q + 5'd1;
                    if ((total_d % PPR) == '0 && round_q != 2'd3) round_d = round_q + 2'd1;
                    state_d = S_POINT;
                    cnt_d   = POINT_CNT;
                end
            end
            S_POINT: begin
                if (left_q == WIN || right_q == WIN) begin
                    state_d = S_OVER;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_CNT;
                    end
                end
            end
            S_OVER: begin
                if (start && !start_q) begin
                    state_d = S_SERVE;
                    cnt_d   = SERVE_CNT;
                    left_d  = '0;
                    right_d = '0;
                    round_d = '0;
                    total_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (paddle_hit || point) begin
            snd_d = SOUND_CNT;
        end else if (frame_tick && snd_q != '0) begin
            snd_d = snd_q - 8'd1;
        end

        ball_d  = (state_d == S_PLAY);
        over_d  = (state_d == S_OVER);
        sound_d = (snd_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snd_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            round_q <= '0;
            total_q <= '0;
            dir_q   <= 1'b0;
            ball_q  <= 1'b0;
            sound_q <= 1'b0;
            over_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snd_q   <= snd_d;
            left_q  <= left_d;
            right_q <= right_d;
            round_q <= round_d;
            total_q <= total_d;
            dir_q   <= dir_d;
            ball_q  <= ball_d;
            sound_q <= sound_d;
            over_q  <= over_d;
            start_q <= start;
        end
    end

    assign left_score  = left_q;
    assign right_score = right_q;
    assign round       = round_q;
    assign ball_enable = ball_q;
    assign serve_dir   = dir_q;
    assign sound_on    = sound_q;
    assign game_over   = over_q;

endmodule
